// File: rtl/bb_shift_result_buffer_pkg.sv
// Shared widths and defaults for the barrel-shifter result buffer.
package bb_shift_result_buffer_pkg;

  localparam int unsigned SB_DATA_W  = 8;
  localparam int unsigned SB_SHAMT_W = 3;
  localparam int unsigned SB_DEPTH   = 4;
  localparam int unsigned SB_CNT_W   = 8;

endpackage

// File: rtl/bb_sbuf_mem.sv
// Result storage: register array with one write port and one asynchronous read port.
module bb_sbuf_mem #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 12
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bb_shift_result_buffer.sv
// FWFT capture FIFO for barrel-shifter results, with sticky overflow and saturating drop count.
module bb_shift_result_buffer
  import bb_shift_result_buffer_pkg::*;
#(
  parameter int unsigned DATA_W  = SB_DATA_W,
  parameter int unsigned SHAMT_W = SB_SHAMT_W,
  parameter int unsigned DEPTH   = SB_DEPTH,
  parameter int unsigned CNT_W   = SB_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SHAMT_W-1:0]       in_shift,
  input  logic                     in_dir,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SHAMT_W-1:0]       out_shift,
  output logic                     out_dir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_W + SHAMT_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               push, pop, drop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign in_ready  = (count_q != COUNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;
  assign wr_entry  = {in_dir, in_shift, in_data};

  bb_sbuf_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign {out_dir, out_shift, out_data} = rd_entry;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Pointer/occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear takes precedence over the clear.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
